// File: rtl/lsu_align_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lsu_align_unit_pkg
// Description : Shared access-type codes, FSM states and sizing helpers for
//               the load/store alignment unit.
// Revision    : 1.0 - initial release
// ============================================================================
package lsu_align_unit_pkg;

  localparam logic [2:0] LSU_LB  = 3'b000;
  localparam logic [2:0] LSU_LH  = 3'b001;
  localparam logic [2:0] LSU_LW  = 3'b010;
  localparam logic [2:0] LSU_LD  = 3'b011;
  localparam logic [2:0] LSU_LBU = 3'b100;
  localparam logic [2:0] LSU_LHU = 3'b101;
  localparam logic [2:0] LSU_LWU = 3'b110;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_RESP  = 3'd3,
    ST_DRAIN = 3'd4
  } lsu_state_e;

  function automatic int lsu_off_w(input int xlen);
    return $clog2(xlen / 8);
  endfunction

  function automatic logic lsu_legal(input logic [2:0] t, input int xlen);
    case (t)
      LSU_LB, LSU_LH, LSU_LW, LSU_LBU, LSU_LHU: return 1'b1;
      LSU_LD, LSU_LWU:                          return (xlen == 64);
      default:                                  return 1'b0;
    endcase
  endfunction

  // log2 of the access size in bytes; an illegal type covers the full bus
  function automatic logic [1:0] lsu_size(input logic [2:0] t, input int xlen);
    if (lsu_legal(t, xlen)) return t[1:0];
    return (xlen == 64) ? 2'd3 : 2'd2;
  endfunction

  function automatic logic [2:0] lsu_low_mask(input logic [1:0] sz);
    return (3'b001 << sz) - 3'b001;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_align_unit_load_extend.sv
`default_nettype none
// ============================================================================
// Module      : lsu_load_extend
// Description : Combinational lane extraction and sign/zero extension of
//               load return data.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_load_extend
  import lsu_align_unit_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int OFF_W = lsu_off_w(XLEN)
) (
  input  logic [2:0]       i_type,
  input  logic [OFF_W-1:0] i_off,
  input  logic [XLEN-1:0]  i_rdata,
  output logic [XLEN-1:0]  o_result
);

  logic [XLEN-1:0] w_shifted;
  logic [XLEN-1:0] w_word_s;
  logic [XLEN-1:0] w_word_u;

  assign w_shifted = i_rdata >> {i_off, 3'b000};

  generate
    if (XLEN == 64) begin : g_x64
      assign w_word_s = {{32{w_shifted[31]}}, w_shifted[31:0]};
      assign w_word_u = {32'b0, w_shifted[31:0]};
    end else begin : g_x32
      assign w_word_s = w_shifted;
      assign w_word_u = w_shifted;
    end
  endgenerate

  always_comb begin
    o_result = i_rdata;
    case (i_type)
      LSU_LB:  o_result = {{(XLEN-8){w_shifted[7]}}, w_shifted[7:0]};
      LSU_LBU: o_result = {{(XLEN-8){1'b0}}, w_shifted[7:0]};
      LSU_LH:  o_result = {{(XLEN-16){w_shifted[15]}}, w_shifted[15:0]};
      LSU_LHU: o_result = {{(XLEN-16){1'b0}}, w_shifted[15:0]};
      LSU_LW:  o_result = w_word_s;
      LSU_LWU: o_result = w_word_u;
      LSU_LD:  o_result = w_shifted;
      default: o_result = i_rdata;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/lsu_align_unit.sv
`default_nettype none
// ============================================================================
// Module      : lsu_align_unit
// Description : Load/store alignment unit: request FSM, store lane packing,
//               load extraction and flush handling. Define
//               LSU_MISALIGN_EXC_EN to report misaligned/illegal accesses
//               instead of truncating the offset.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_align_unit
  import lsu_align_unit_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                flush,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [2:0]          req_type,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [XLEN-1:0]     req_wdata,
  output logic                resp_valid,
  output logic [XLEN-1:0]     resp_rdata,
  output logic                resp_misalign,
  output logic                mem_req,
  input  logic                mem_gnt,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [XLEN/8-1:0]   mem_be,
  output logic [XLEN-1:0]     mem_wdata,
  input  logic                mem_rvalid,
  input  logic [XLEN-1:0]     mem_rdata
);

  localparam int BE_W  = XLEN / 8;
  localparam int OFF_W = lsu_off_w(XLEN);

  lsu_state_e         r_state;
  lsu_state_e         w_state_nxt;
  logic               r_we;
  logic [2:0]         r_type;
  logic [ADDR_W-1:0]  r_addr;
  logic [XLEN-1:0]    r_wdata;
  logic [XLEN-1:0]    r_rdata;

  logic               w_accept;
  logic [1:0]         w_size;
  logic [2:0]         w_lowm;
  logic [OFF_W-1:0]   w_off;
  logic [BE_W-1:0]    w_size_mask;
  logic [BE_W-1:0]    w_be;
  logic [XLEN-1:0]    w_wdata_rep;
  logic [XLEN-1:0]    w_ld_result;

  assign w_accept = req_valid && req_ready && !flush;

`ifdef LSU_MISALIGN_EXC_EN
  logic               r_mis;
  logic [1:0]         w_req_size;
  logic [2:0]         w_req_lowm;
  logic               w_req_mis;

  assign w_req_size = lsu_size(req_type, XLEN);
  assign w_req_lowm = lsu_low_mask(w_req_size);
  assign w_req_mis  = !lsu_legal(req_type, XLEN) ||
                      ((req_addr[OFF_W-1:0] & w_req_lowm[OFF_W-1:0]) != '0);
`endif

  // Offset is forced down to the access-size boundary so a misaligned access
  // that reaches memory still lands on a legal lane.
  assign w_size = lsu_size(r_type, XLEN);
  assign w_lowm = lsu_low_mask(w_size);
  assign w_off  = r_addr[OFF_W-1:0] & ~w_lowm[OFF_W-1:0];

  always_comb begin
    w_size_mask = '0;
    for (int i = 0; i < BE_W; i++) begin
      w_size_mask[i] = (i < (1 << w_size));
    end
  end

  assign w_be = w_size_mask << w_off;

  always_comb begin
    w_wdata_rep = '0;
    for (int i = 0; i < BE_W; i++) begin
      case (w_size)
        2'd0:    w_wdata_rep[i*8 +: 8] = r_wdata[7:0];
        2'd1:    w_wdata_rep[i*8 +: 8] = r_wdata[(i%2)*8 +: 8];
        2'd2:    w_wdata_rep[i*8 +: 8] = r_wdata[(i%4)*8 +: 8];
        default: w_wdata_rep[i*8 +: 8] = r_wdata[(i%8)*8 +: 8];
      endcase
    end
  end

  lsu_load_extend #(
    .XLEN  (XLEN),
    .OFF_W (OFF_W)
  ) u_load_extend (
    .i_type   (r_type),
    .i_off    (w_off),
    .i_rdata  (mem_rdata),
    .o_result (w_ld_result)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
`ifdef LSU_MISALIGN_EXC_EN
          w_state_nxt = w_req_mis ? ST_RESP : ST_REQ;
`else
          w_state_nxt = ST_REQ;
`endif
        end
      end
      ST_REQ: begin
        if (mem_gnt) begin
          if (flush)      w_state_nxt = ST_DRAIN;
          else if (r_we)  w_state_nxt = ST_RESP;
          else            w_state_nxt = ST_WAIT;
        end else if (flush) begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_WAIT: begin
        // Data returning in the flush cycle means nothing is left to drain
        if (flush)           w_state_nxt = mem_rvalid ? ST_IDLE : ST_DRAIN;
        else if (mem_rvalid) w_state_nxt = ST_RESP;
      end
      ST_RESP:  w_state_nxt = ST_IDLE;
      ST_DRAIN: begin
        if (r_we || mem_rvalid) w_state_nxt = ST_IDLE;
      end
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= ST_IDLE;
      r_we    <= 1'b0;
      r_type  <= 3'b000;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
`ifdef LSU_MISALIGN_EXC_EN
      r_mis   <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_we    <= req_we;
        r_type  <= req_type;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
`ifdef LSU_MISALIGN_EXC_EN
        r_mis   <= w_req_mis;
        if (w_req_mis) r_rdata <= '0;
`endif
      end
      if (r_state == ST_WAIT && mem_rvalid && !flush) begin
        r_rdata <= w_ld_result;
      end
    end
  end

  assign req_ready  = (r_state == ST_IDLE);
  assign resp_valid = (r_state == ST_RESP);
  assign resp_rdata = r_rdata;
  assign mem_req    = (r_state == ST_REQ);
  assign mem_we     = mem_req && r_we;
  assign mem_be     = mem_req ? w_be : '0;
  assign mem_addr   = {r_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  assign mem_wdata  = w_wdata_rep;

`ifdef LSU_MISALIGN_EXC_EN
  assign resp_misalign = resp_valid && r_mis;
`else
  assign resp_misalign = 1'b0;
`endif

endmodule
`default_nettype wire

// File: doc/lsu_align_unit.md
LSU_ALIGN_UNIT -- requirements
Module: lsu_align_unit

Interface
REQ-001 The module SHALL have parameter XLEN, default 32; pipeline and memory data width, legal values 32 or 64.
REQ-002 The module SHALL have parameter ADDR_W, default 32; byte-address width.
REQ-003 The module SHALL have port clk  input  1  the single clock; all state changes on the rising edge.
REQ-004 The module SHALL have port rstn  input  1  reset; asynchronous and active-low.
REQ-005 The module SHALL have port flush  input  1  abort the in-flight access.
REQ-006 The module SHALL have ports req_valid/req_ready  input/output  1/1  pipeline request handshake.
REQ-007 The module SHALL have ports req_we  input  1, req_type  input  3, req_addr  input  ADDR_W, req_wdata  input  XLEN; store flag, access type (LB/LBU/LH/LHU/LW, plus LWU/LD when XLEN=64), byte address, store data.
REQ-008 The module SHALL have ports resp_valid  output  1, resp_rdata  output  XLEN, resp_misalign  output  1; one-cycle completion pulse, extended load data, misalignment flag.
REQ-009 The module SHALL have ports mem_req  output  1, mem_gnt  input  1, mem_we  output  1, mem_addr  output  ADDR_W (XLEN/8-aligned), mem_be  output  XLEN/8, mem_wdata  output  XLEN; memory command channel.
REQ-010 The module SHALL have ports mem_rvalid  input  1, mem_rdata  input  XLEN; memory read return.

Function
REQ-011 The FSM SHALL have states IDLE, REQ, WAIT, RESP and DRAIN; req_ready = (state==IDLE).
REQ-012 IDLE: req_valid&&req_ready SHALL register we, type, addr, wdata and go to REQ; illegal req_type SHALL be treated as a misaligned access.
REQ-013 REQ: mem_req SHALL be held high with stable mem_we/mem_addr/mem_be/mem_wdata until mem_gnt; on gnt a store SHALL go to RESP and a load SHALL go to WAIT.
REQ-014 WAIT: on mem_rvalid the extended load result SHALL be captured and the FSM SHALL go to RESP; mem_rvalid in the same cycle as mem_gnt SHALL NOT occur.
REQ-015 RESP: resp_valid SHALL be high for exactly one cycle, then IDLE; minimum latency SHALL be 3 cycles from accept to resp_valid for stores and 4 cycles for loads.
REQ-016 Lane select: off = addr[log2(XLEN/8)-1:0]; a load SHALL extract byte/half/word at lane off from mem_rdata, sign-extending for LB/LH/LW (XLEN=64) and zero-extending for LBU/LHU/LWU.
REQ-017 Store: mem_be SHALL equal the size mask (1, 3, 0xF, 0xFF) shifted left by off; mem_wdata SHALL equal the low size bytes of wdata replicated into every lane.
REQ-018 mem_addr SHALL be addr with its low log2(XLEN/8) bits cleared.
REQ-019 Misaligned means off is not a multiple of the access size; handling SHALL follow REQ-025/026.
REQ-020 flush in REQ before gnt SHALL go to IDLE with no response; flush in REQ on the gnt cycle or in WAIT SHALL go to DRAIN.
REQ-021 DRAIN SHALL wait for the outstanding mem_rvalid (loads) or one cycle (stores), then IDLE, with no resp_valid.
REQ-022 flush in IDLE or RESP SHALL have no effect on a response already being presented; a flush and req_valid in the same IDLE cycle SHALL block acceptance.

Reset
REQ-023 Asserting rstn low SHALL force state IDLE, and resp_valid, mem_req, mem_we, mem_be and resp_misalign to 0 immediately and asynchronously.
REQ-024 While rstn is low, resp_rdata, mem_addr and mem_wdata SHALL read 0; a reset mid-access SHALL silently drop the transaction, and the memory must tolerate the orphaned rvalid.

Configuration
REQ-025 With LSU_MISALIGN_EXC_EN defined, a misaligned or illegal access SHALL skip memory (no mem_req), go IDLE->RESP, and pulse resp_valid with resp_misalign=1 and resp_rdata=0.
REQ-026 Without LSU_MISALIGN_EXC_EN, off SHALL be truncated down to the access-size alignment, the access SHALL proceed normally, and resp_misalign SHALL be tied 0.

Structure
REQ-027 Load/store type codes and the XLEN-to-offset-width function SHALL live in the shared defines package and be used in place of local constants.
REQ-028 The lane extract/extend datapath SHALL be one sub-module, lsu_load_extend (combinational; type, off, rdata -> XLEN result); the FSM, store packing and flush logic SHALL stay in lsu_align_unit.

Verification
REQ-029 XLEN=32, LB addr 0x103, mem_rdata 0x80FF_1234 -> resp_rdata 0xFFFF_FF80, mem_addr 0x100, resp 4 cycles after accept with gnt and rvalid at the earliest cycle.
REQ-030 LHU addr 0x102, mem_rdata 0xBEEF_0000 -> resp_rdata 0x0000_BEEF; LH at the same address -> 0xFFFF_BEEF.
REQ-031 SB addr 0x201, wdata 0x1234_56AB -> mem_be 4'b0010, mem_wdata 0xABAB_ABAB; SH addr 0x202 -> mem_be 4'b1100.
REQ-032 LW addr 0x102: with LSU_MISALIGN_EXC_EN -> no mem_req, resp_misalign=1; without it -> mem_addr 0x100, be 4'hF.
REQ-033 Load with gnt delayed 3 cycles then flush in WAIT -> DRAIN, no resp_valid, req_ready returns the cycle after rvalid.
REQ-034 XLEN=64, LWU addr 0x0C, mem_rdata 0x8000_0001_xxxx_xxxx -> resp_rdata 0x0000_0000_8000_0001; rstn low mid-WAIT -> all outputs 0 in the same cycle.
